// File: rtl/cbus_arbiter.sv
// cbus_arbiter
// Shares one 64-bit memory request port between the instruction-fetch bus
// (I) and the data bus (D). One transaction is in flight at a time: the
// winning request is captured on grant, presented as an address phase
// (REQ) and then waits for its data phase (RESP), whose response is routed
// back only to the owning requester.
//
// Parameters
//   FAIR      : 0 = D always wins simultaneous requests,
//               1 = simultaneous requests go to the bus not granted last.
//   IWORD_SEL : 1 = instruction word is the 32-bit half picked by addr[2],
//               0 = instruction word is always the low half.
//
// Ports
//   clk, reset (async, active-low)
//   ireq_valid/ireq_addr                      fetch request
//   iresp_addr_ok/iresp_data_ok/iresp_data     fetch response
//   dreq_valid/addr/size/strobe/data           data request (strobe 0 = read)
//   dresp_addr_ok/dresp_data_ok/dresp_data     data response
//   mreq_valid/addr/size/strobe/data, mreq_ready   memory request port
//   mresp_valid/mresp_data                     memory response port
//   busy                                       a transaction is owned
module cbus_arbiter #(
  parameter bit FAIR      = 1'b0,
  parameter bit IWORD_SEL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,

  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,

  output logic        mreq_valid,
  output logic [63:0] mreq_addr,
  output logic [2:0]  mreq_size,
  output logic [7:0]  mreq_strobe,
  output logic [63:0] mreq_data,
  input  logic        mreq_ready,
  input  logic        mresp_valid,
  input  logic [63:0] mresp_data,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Instruction fetches are always 32-bit reads.
  localparam logic [2:0] ISIZE = 3'b010;

  state_t      state, state_nx;
  logic        owner_d;       // 1 = data bus owns the transaction
  logic        last_grant_d;  // 1 = data bus was granted last
  logic        grant;
  logic        grant_d;
  logic [63:0] lat_addr;
  logic [2:0]  lat_size;
  logic [7:0]  lat_strobe;
  logic [63:0] lat_data;

  logic        addr_ok;
  logic        data_ok;
  logic [31:0] iword;

  // Grant decision and next state.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        if (ireq_valid || dreq_valid) begin
          grant    = 1'b1;
          state_nx = REQ;
          if (ireq_valid && dreq_valid) begin
            // Data priority unless fairness mode alternates under contention.
            grant_d = FAIR ? ~last_grant_d : 1'b1;
          end else begin
            grant_d = dreq_valid;
          end
        end
      end
      REQ: begin
        if (mreq_ready) state_nx = RESP;
      end
      RESP: begin
        if (mresp_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, ownership and request capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      last_grant_d <= 1'b0;
      lat_addr     <= '0;
      lat_size     <= '0;
      lat_strobe   <= '0;
      lat_data     <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner_d      <= grant_d;
        last_grant_d <= grant_d;
        if (grant_d) begin
          lat_addr   <= dreq_addr;
          lat_size   <= dreq_size;
          lat_strobe <= dreq_strobe;
          lat_data   <= dreq_data;
        end else begin
          lat_addr   <= ireq_addr;
          lat_size   <= ISIZE;
          lat_strobe <= '0;
          lat_data   <= '0;
        end
      end
    end
  end

  // Memory side is driven straight from the captured request, so it stays
  // stable for as long as the memory stalls the address phase.
  assign mreq_valid  = (state == REQ);
  assign mreq_addr   = lat_addr;
  assign mreq_size   = lat_size;
  assign mreq_strobe = lat_strobe;
  assign mreq_data   = lat_data;

  assign addr_ok = (state == REQ)  && mreq_ready;
  assign data_ok = (state == RESP) && mresp_valid;

  assign iresp_addr_ok = addr_ok & ~owner_d;
  assign dresp_addr_ok = addr_ok &  owner_d;
  assign iresp_data_ok = data_ok & ~owner_d;
  assign dresp_data_ok = data_ok &  owner_d;

  assign iword = (IWORD_SEL && lat_addr[2]) ? mresp_data[63:32] : mresp_data[31:0];

  // Response data is held at zero except while it is being delivered.
  assign iresp_data = iresp_data_ok ? iword      : 32'd0;
  assign dresp_data = dresp_data_ok ? mresp_data : 64'd0;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter. Two instances run side by side: instance 0 with
// FAIR=0/IWORD_SEL=1 and instance 1 with FAIR=1/IWORD_SEL=0. Each has its
// own requester/memory agent and its own transaction-level reference model.
module tb_cbus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ireq_valid[2];
  logic [63:0] ireq_addr[2];
  logic        iresp_addr_ok[2];
  logic        iresp_data_ok[2];
  logic [31:0] iresp_data[2];
  logic        dreq_valid[2];
  logic [63:0] dreq_addr[2];
  logic [2:0]  dreq_size[2];
  logic [7:0]  dreq_strobe[2];
  logic [63:0] dreq_data[2];
  logic        dresp_addr_ok[2];
  logic        dresp_data_ok[2];
  logic [63:0] dresp_data[2];
  logic        mreq_valid[2];
  logic [63:0] mreq_addr[2];
  logic [2:0]  mreq_size[2];
  logic [7:0]  mreq_strobe[2];
  logic [63:0] mreq_data[2];
  logic        mreq_ready[2];
  logic        mresp_valid[2];
  logic [63:0] mresp_data[2];
  logic        busy[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cbus_arbiter #(.FAIR(g == 1), .IWORD_SEL(g == 0)) u_dut (
      .clk(clk), .reset(rst_n),
      .ireq_valid(ireq_valid[g]), .ireq_addr(ireq_addr[g]),
      .iresp_addr_ok(iresp_addr_ok[g]), .iresp_data_ok(iresp_data_ok[g]),
      .iresp_data(iresp_data[g]),
      .dreq_valid(dreq_valid[g]), .dreq_addr(dreq_addr[g]), .dreq_size(dreq_size[g]),
      .dreq_strobe(dreq_strobe[g]), .dreq_data(dreq_data[g]),
      .dresp_addr_ok(dresp_addr_ok[g]), .dresp_data_ok(dresp_data_ok[g]),
      .dresp_data(dresp_data[g]),
      .mreq_valid(mreq_valid[g]), .mreq_addr(mreq_addr[g]), .mreq_size(mreq_size[g]),
      .mreq_strobe(mreq_strobe[g]), .mreq_data(mreq_data[g]),
      .mreq_ready(mreq_ready[g]), .mresp_valid(mresp_valid[g]), .mresp_data(mresp_data[g]),
      .busy(busy[g])
    );
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- agent knobs ----------------
  int          cyc = 0;
  int          i_pend[2];
  int          d_pend[2];
  bit          rand_en = 1'b0;
  bit          scramble = 1'b0;
  int          rdy_pct = 100;
  int          rsp_pct = 100;
  bit          fix_rd = 1'b0;
  logic [63:0] rd_val = '0;
  logic [63:0] i_next_addr = '0;
  logic [63:0] d_next_addr = '0;
  logic [2:0]  d_next_size = '0;
  logic [7:0]  d_next_strobe = '0;
  logic [63:0] d_next_data = '0;
  logic        i_seen_ok[2];
  logic        d_seen_ok[2];
  int          i_raise_cyc[2];

  task automatic new_i(input int k);
    ireq_valid[k] = 1'b1;
    if (i_pend[k] > 0) begin
      ireq_addr[k] = i_next_addr;
      i_pend[k]--;
    end else begin
      ireq_addr[k] = rnd64();
    end
    i_raise_cyc[k] = cyc;
  endtask

  task automatic new_d(input int k);
    dreq_valid[k] = 1'b1;
    if (d_pend[k] > 0) begin
      dreq_addr[k]   = d_next_addr;
      dreq_size[k]   = d_next_size;
      dreq_strobe[k] = d_next_strobe;
      dreq_data[k]   = d_next_data;
      d_pend[k]--;
    end else begin
      dreq_addr[k]   = rnd64();
      dreq_size[k]   = 3'($urandom_range(3));
      dreq_strobe[k] = ($urandom_range(1) == 1) ? 8'($urandom) : 8'd0;
      dreq_data[k]   = rnd64();
    end
  endtask

  // Requesters hold valid until they see data_ok, then either drop it or
  // immediately present the next request. Memory signals are random/forced.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ireq_valid[k] = 1'b0;
        dreq_valid[k] = 1'b0;
      end else begin
        if (ireq_valid[k] && i_seen_ok[k]) begin
          if (i_pend[k] > 0) new_i(k); else ireq_valid[k] = 1'b0;
        end else if (!ireq_valid[k]) begin
          if (i_pend[k] > 0 || (rand_en && $urandom_range(99) < 30)) new_i(k);
        end else if (scramble) begin
          ireq_addr[k] = rnd64();
        end
        if (dreq_valid[k] && d_seen_ok[k]) begin
          if (d_pend[k] > 0) new_d(k); else dreq_valid[k] = 1'b0;
        end else if (!dreq_valid[k]) begin
          if (d_pend[k] > 0 || (rand_en && $urandom_range(99) < 30)) new_d(k);
        end else if (scramble) begin
          dreq_addr[k]   = rnd64();
          dreq_strobe[k] = 8'($urandom);
          dreq_data[k]   = rnd64();
        end
      end
      mreq_ready[k]  = ($urandom_range(99) < rdy_pct);
      mresp_valid[k] = ($urandom_range(99) < rsp_pct);
      mresp_data[k]  = fix_rd ? rd_val : rnd64();
    end
  end

  // ---------------- reference model + event logs ----------------
  // Model: a transaction is either absent, waiting for its address to be
  // accepted, or waiting for its data. Ownership follows the arbitration rule.
  bit          m_busy[2];
  bit          m_acc[2];
  bit          m_own_d[2];
  bit          m_last_d[2];
  logic [63:0] m_addr[2];
  logic [2:0]  m_size[2];
  logic [7:0]  m_strb[2];
  logic [63:0] m_data[2];

  logic        g_own[2][64];
  logic [63:0] g_addr[2][64];
  logic [2:0]  g_size[2][64];
  logic [7:0]  g_strb[2][64];
  logic [63:0] g_data[2][64];
  int          g_n[2];
  int          nid[2];
  int          ndd[2];
  int          req_cyc[2];
  logic [31:0] last_idata[2];
  int          last_idok_cyc[2];

  always @(negedge clk) begin
    bit          e_mv, e_iaok, e_daok, e_idok, e_ddok, pick_d;
    logic [5:0]  e_ctl, a_ctl;
    logic [31:0] e_word;
    for (int k = 0; k < 2; k++) begin
      i_seen_ok[k] = iresp_data_ok[k];
      d_seen_ok[k] = dresp_data_ok[k];
      a_ctl = {busy[k], mreq_valid[k], iresp_addr_ok[k], dresp_addr_ok[k],
               iresp_data_ok[k], dresp_data_ok[k]};
      if (!rst_n) begin
        m_busy[k] = 1'b0; m_acc[k] = 1'b0; m_own_d[k] = 1'b0; m_last_d[k] = 1'b0;
        m_addr[k] = '0; m_size[k] = '0; m_strb[k] = '0; m_data[k] = '0;
        chk("reset_ctl", k, 64'(a_ctl), 64'd0);
        chk("reset_mreq_addr", k, mreq_addr[k], 64'd0);
      end else begin
        e_mv   = m_busy[k] && !m_acc[k];
        e_iaok = e_mv && mreq_ready[k] && !m_own_d[k];
        e_daok = e_mv && mreq_ready[k] &&  m_own_d[k];
        e_idok = m_busy[k] && m_acc[k] && mresp_valid[k] && !m_own_d[k];
        e_ddok = m_busy[k] && m_acc[k] && mresp_valid[k] &&  m_own_d[k];
        e_ctl  = {m_busy[k], e_mv, e_iaok, e_daok, e_idok, e_ddok};
        chk("ctl", k, 64'(a_ctl), 64'(e_ctl));
        if (e_mv) begin
          chk("mreq_addr", k, mreq_addr[k], m_addr[k]);
          chk("mreq_size", k, 64'(mreq_size[k]), 64'(m_size[k]));
          chk("mreq_strobe", k, 64'(mreq_strobe[k]), 64'(m_strb[k]));
          chk("mreq_data", k, mreq_data[k], m_data[k]);
        end
        if (e_idok) begin
          e_word = (k == 0 && m_addr[k][2]) ? mresp_data[k][63:32] : mresp_data[k][31:0];
          chk("iresp_data", k, 64'(iresp_data[k]), 64'(e_word));
        end
        if (e_ddok) chk("dresp_data", k, dresp_data[k], mresp_data[k]);

        // advance the model to the next cycle
        if (!m_busy[k]) begin
          if (ireq_valid[k] || dreq_valid[k]) begin
            if (ireq_valid[k] && dreq_valid[k]) pick_d = (k == 1) ? !m_last_d[k] : 1'b1;
            else pick_d = dreq_valid[k];
            m_own_d[k] = pick_d; m_last_d[k] = pick_d;
            m_busy[k] = 1'b1; m_acc[k] = 1'b0;
            if (pick_d) begin
              m_addr[k] = dreq_addr[k]; m_size[k] = dreq_size[k];
              m_strb[k] = dreq_strobe[k]; m_data[k] = dreq_data[k];
            end else begin
              m_addr[k] = ireq_addr[k]; m_size[k] = 3'd2; m_strb[k] = '0; m_data[k] = '0;
            end
          end
        end else if (!m_acc[k]) begin
          if (mreq_ready[k]) m_acc[k] = 1'b1;
        end else if (mresp_valid[k]) begin
          m_busy[k] = 1'b0; m_acc[k] = 1'b0;
        end
      end
      // DUT-observed event log
      if (iresp_addr_ok[k] || dresp_addr_ok[k]) begin
        if (g_n[k] < 64) begin
          g_own[k][g_n[k]]  = dresp_addr_ok[k];
          g_addr[k][g_n[k]] = mreq_addr[k];
          g_size[k][g_n[k]] = mreq_size[k];
          g_strb[k][g_n[k]] = mreq_strobe[k];
          g_data[k][g_n[k]] = mreq_data[k];
        end
        g_n[k]++;
      end
      if (iresp_data_ok[k]) begin
        nid[k]++; last_idata[k] = iresp_data[k]; last_idok_cyc[k] = cyc;
      end
      if (dresp_data_ok[k]) ndd[k]++;
      if (mreq_valid[k]) req_cyc[k]++;
    end
  end

  // ---------------- directed sequences ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      g_n[k] = 0; nid[k] = 0; ndd[k] = 0; req_cyc[k] = 0;
    end
  endtask

  function automatic bit all_idle();
    for (int k = 0; k < 2; k++)
      if (i_pend[k] != 0 || d_pend[k] != 0 || ireq_valid[k] || dreq_valid[k] || busy[k])
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string nm, input int maxc);
    int n = 0;
    while (!all_idle() && n < maxc) begin
      step();
      n++;
    end
    if (!all_idle()) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", nm, maxc);
    end
  endtask

  initial begin
    int n;
    int alt;
    int nd;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ireq_valid[k] = 1'b0; ireq_addr[k] = '0;
      dreq_valid[k] = 1'b0; dreq_addr[k] = '0; dreq_size[k] = '0;
      dreq_strobe[k] = '0; dreq_data[k] = '0;
      mreq_ready[k] = 1'b0; mresp_valid[k] = 1'b0; mresp_data[k] = '0;
      i_pend[k] = 0; d_pend[k] = 0; i_seen_ok[k] = 1'b0; d_seen_ok[k] = 1'b0;
      i_raise_cyc[k] = 0; last_idok_cyc[k] = 0; last_idata[k] = '0;
    end
    clear_logs();
    #2 rst_n = 1'b0;
    step(); step(); step();
    for (int k = 0; k < 2; k++) chk("reset_busy", k, 64'(busy[k]), 64'd0);
    rst_n = 1'b1;
    step();

    // A: single fetch, minimum latency, word select
    clear_logs();
    fix_rd = 1'b1; rd_val = 64'h1111_2222_3333_4444;
    i_next_addr = 64'h8000_0004;
    for (int k = 0; k < 2; k++) i_pend[k] = 1;
    wait_idle("fetch_done", 50);
    for (int k = 0; k < 2; k++) begin
      chk("fetch_grants", k, 64'(g_n[k]), 64'd1);
      chk("fetch_owner", k, 64'(g_own[k][0]), 64'd0);
      chk("fetch_addr", k, g_addr[k][0], 64'h8000_0004);
      chk("fetch_size", k, 64'(g_size[k][0]), 64'd2);
      chk("fetch_strobe", k, 64'(g_strb[k][0]), 64'd0);
      chk("fetch_latency", k, 64'(last_idok_cyc[k] - i_raise_cyc[k]), 64'd2);
      chk("fetch_dataok_count", k, 64'(nid[k]), 64'd1);
    end
    chk("fetch_word_hi", 0, 64'(last_idata[0]), 64'h1111_2222);
    chk("fetch_word_lo", 1, 64'(last_idata[1]), 64'h3333_4444);

    // B: contention after a data grant
    fix_rd = 1'b0;
    d_next_addr = 64'h1000; d_next_size = 3'd3; d_next_strobe = 8'd0; d_next_data = '0;
    for (int k = 0; k < 2; k++) d_pend[k] = 1;
    wait_idle("solo_d", 50);
    clear_logs();
    d_next_addr = 64'h2000; i_next_addr = 64'h3000;
    for (int k = 0; k < 2; k++) begin i_pend[k] = 1; d_pend[k] = 1; end
    wait_idle("contend", 80);
    chk("contend_grants", 0, 64'(g_n[0]), 64'd2);
    chk("contend_grants", 1, 64'(g_n[1]), 64'd2);
    chk("nofair_first_is_d", 0, 64'(g_own[0][0]), 64'd1);
    chk("nofair_second_is_i", 0, 64'(g_own[0][1]), 64'd0);
    chk("nofair_first_addr", 0, g_addr[0][0], 64'h2000);
    chk("fair_first_is_i", 1, 64'(g_own[1][0]), 64'd0);
    chk("fair_second_is_d", 1, 64'(g_own[1][1]), 64'd1);

    // C: store stalled 4 cycles by mreq_ready, mresp_valid high throughout
    clear_logs();
    rdy_pct = 0; rsp_pct = 100;
    d_next_addr = 64'h8000_0010; d_next_size = 3'd2;
    d_next_strobe = 8'h0F; d_next_data = 64'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) d_pend[k] = 1;
    for (int s = 0; s < 5; s++) step();
    rdy_pct = 100;
    wait_idle("store", 50);
    for (int k = 0; k < 2; k++) begin
      chk("store_addr_ok_count", k, 64'(g_n[k]), 64'd1);
      chk("store_req_cycles", k, 64'(req_cyc[k]), 64'd5);
      chk("store_addr", k, g_addr[k][0], 64'h8000_0010);
      chk("store_strobe", k, 64'(g_strb[k][0]), 64'h0F);
      chk("store_data", k, g_data[k][0], 64'hDEAD_BEEF);
      chk("store_data_ok_count", k, 64'(ndd[k]), 64'd1);
      chk("store_no_iresp", k, 64'(nid[k]), 64'd0);
    end

    // E: reset while waiting for the data phase
    clear_logs();
    rdy_pct = 100; rsp_pct = 0;
    for (int k = 0; k < 2; k++) d_pend[k] = 1;
    step(); step(); step();
    for (int k = 0; k < 2; k++) chk("resp_busy_before_reset", k, 64'(busy[k]), 64'd1);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) d_pend[k] = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("abort_ctl", k, 64'({busy[k], mreq_valid[k], iresp_addr_ok[k], dresp_addr_ok[k],
                               iresp_data_ok[k], dresp_data_ok[k]}), 64'd0);
      chk("abort_mreq_addr", k, mreq_addr[k], 64'd0);
    end
    rsp_pct = 100;
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    for (int k = 0; k < 2; k++) begin
      chk("abort_no_data_ok", k, 64'(ndd[k]), 64'd0);
      chk("abort_idle", k, 64'(busy[k]), 64'd0);
    end

    // F: sustained contention
    clear_logs();
    rdy_pct = 60; rsp_pct = 60;
    for (int k = 0; k < 2; k++) begin i_pend[k] = 12; d_pend[k] = 12; end
    n = 0;
    while ((g_n[0] < 10 || g_n[1] < 10) && n < 2000) begin step(); n++; end
    if (g_n[0] < 10 || g_n[1] < 10) begin
      n_cmp++; n_fail++;
      $display("FAIL sustained_progress: grants %0d/%0d, expected 10 each", g_n[0], g_n[1]);
    end
    for (int k = 0; k < 2; k++) begin i_pend[k] = 0; d_pend[k] = 0; end
    wait_idle("sustained_drain", 500);
    nd = 0; alt = 0;
    for (int j = 0; j < 10; j++) begin
      if (g_own[0][j]) nd++;
      if (j > 0 && g_own[1][j] != g_own[1][j-1]) alt++;
    end
    chk("nofair_all_d", 0, 64'(nd), 64'd10);
    chk("fair_first_d", 1, 64'(g_own[1][0]), 64'd1);
    chk("fair_alternations", 1, 64'(alt), 64'd9);

    // Random traffic checked cycle by cycle against the model
    rand_en = 1'b1; scramble = 1'b1; rdy_pct = 50; rsp_pct = 50;
    for (int s = 0; s < 3000; s++) step();
    rand_en = 1'b0; scramble = 1'b0;
    wait_idle("random_drain", 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares a single 64-bit memory port between the core's instruction bus (fetch) and data bus (memory stage).
- Sits between `core` and the memory/cache interface.
- Only one transaction is outstanding at a time. The request is latched on grant, issued as address phase then data phase, and the response is routed back to the owning requester.
- Data-side priority keeps the memory stage from deadlocking behind fetch. An optional fairness mode alternates grants under contention.

Parameters:
- FAIR, 0: 0 = data bus always wins simultaneous requests; 1 = on simultaneous requests, grant the bus not granted last.
- IWORD_SEL, 1: 1 = iresp_data selects the 32-bit half of mresp_data by latched addr[2]; 0 = always the low half.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- ireq_valid  in  1  fetch request valid
- ireq_addr  in  64  fetch address
- iresp_addr_ok  out  1  fetch address accepted
- iresp_data_ok  out  1  fetch data valid
- iresp_data  out  32  instruction word
- dreq_valid  in  1  data request valid
- dreq_addr  in  64  data address
- dreq_size  in  3  access size (log2 bytes)
- dreq_strobe  in  8  byte write strobes; 0 = read
- dreq_data  in  64  write data
- dresp_addr_ok  out  1  data address accepted
- dresp_data_ok  out  1  data response valid
- dresp_data  out  64  read data
- mreq_valid  out  1  memory request valid
- mreq_addr  out  64  memory address
- mreq_size  out  3  memory access size
- mreq_strobe  out  8  memory write strobes
- mreq_data  out  64  memory write data
- mreq_ready  in  1  memory accepts request this cycle
- mresp_valid  in  1  memory response valid
- mresp_data  in  64  memory read data
- busy  out  1  arbiter owns a transaction (state != IDLE)

Behaviour:
- FSM states: IDLE, REQ, RESP.
- Registers: owner (I/D), last_grant (I/D), latched addr/size/strobe/data.
- Reset (reset==0, asynchronous):
  - state=IDLE, owner=I, last_grant=I.
  - All latched fields 0.
  - All outputs 0.
  - Any in-flight memory response is abandoned; the memory side shares the reset.
- IDLE, choosing the owner:
  - dreq_valid only -> owner=D.
  - ireq_valid only -> owner=I.
  - Both with FAIR=0 -> owner=D.
  - Both with FAIR=1 -> owner is the opposite of last_grant.
- IDLE, on any grant:
  - Latch the owner's request fields.
  - For I: size=3'b010, strobe=0, data=0.
  - Set last_grant=owner and go to REQ next cycle.
  - With no request, stay in IDLE.
- REQ:
  - mreq_valid=1 and mreq_* are driven from the latches.
  - Requester inputs are ignored while not in IDLE.
  - When mreq_ready=1: the owner's *_addr_ok=1 in the same cycle (combinational) and the FSM goes to RESP.
  - Otherwise it holds, and mreq_* stay stable.
- RESP:
  - mreq_valid=0.
  - When mresp_valid=1: the owner's *_data_ok=1 in the same cycle, with data passed through combinationally, and the FSM goes to IDLE.
  - iresp_data = latched addr[2] ? mresp_data[63:32] : mresp_data[31:0] (IWORD_SEL=1); with IWORD_SEL=0 it is always the low half.
  - dresp_data = mresp_data.
- mresp_valid outside RESP is ignored. mreq_ready outside REQ is ignored.
- Non-owner addr_ok/data_ok are always 0. At most one *_data_ok is high in any cycle.
- Minimum latency is 3 cycles from request to data_ok, with mreq_ready and mresp_valid each high on their first eligible cycle: grant cycle, REQ cycle, RESP cycle.
- Back-to-back transactions: IDLE is revisited for one cycle between transactions.
  - A requester still holding valid in that cycle is treated as a new request.
  - Requesters must drop valid on seeing data_ok.
- A write is a transaction with dreq_strobe != 0. It completes on mresp_valid like a read; mresp_data is forwarded but meaningless.
- Reset asserted in REQ or RESP: return to IDLE immediately. No addr_ok/data_ok is issued for the aborted transaction.

Test Plan:
- Reset, then ireq_valid=1 with addr=0x8000_0004 -> mreq_valid=1, mreq_addr=0x8000_0004, size=3'b010, strobe=0 in cycle 2. mreq_ready=1 -> iresp_addr_ok=1. mresp_data=0x1111_2222_3333_4444 -> iresp_data_ok=1, iresp_data=0x1111_2222.
- Simultaneous ireq_valid and dreq_valid with FAIR=0 -> D granted first; I served in the next IDLE slot. With FAIR=1 and last_grant=D -> I granted first.
- dreq store to addr=0x8000_0010, strobe=8'h0F, data=0xDEAD_BEEF, with mreq_ready held low 4 cycles -> mreq_* stable across all 4 cycles. dresp_addr_ok pulses once, on the ready cycle.
- mresp_valid pulsed while in IDLE or REQ -> no data_ok on either bus, state unchanged.
- Reset dropped to 0 in RESP with dreq pending -> outputs 0 immediately; after release, state=IDLE and no spurious dresp_data_ok.
- Sustained contention with FAIR=0, both valid for 10 transactions -> all grants go to D. With FAIR=1 -> grants strictly alternate D, I, D, I.
